// File: rtl/pmem_scheduler_if.sv
// Bundle of L1 I/D request signals and the physical-memory port seen by pmem_scheduler.
interface pmem_scheduler_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [LINE_W-1:0] pmem_rdata;

   // Caches and memory model together form the master side.
   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_resp, pmem_rdata,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_resp, pmem_rdata,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/pmem_scheduler.sv
// Schedules I/D L1 line traffic onto one pmem port with a one-entry write-back buffer,
// D-over-I priority bounded by a starvation counter, and read forwarding from the buffer.
module pmem_scheduler #(
   parameter int ADDR_W     = 32,
   parameter int LINE_W     = 256,
   parameter int STARVE_MAX = 4
) (
   input logic             clk,
   input logic             rst,
   pmem_scheduler_if.slave bus
);
   localparam int OFS   = $clog2(LINE_W / 8);
   localparam int TAG_W = ADDR_W - OFS;
   localparam int SW    = $clog2(STARVE_MAX + 1);

   typedef enum logic [2:0] {IDLE, RD_I, RD_D, DRAIN, FWD, RESP} state_e;
   typedef enum logic {SIDE_I, SIDE_D} side_e;

   state_e            state_q, state_d;
   side_e             side_q, side_d;
   logic [TAG_W-1:0]  addr_q, addr_d;
   logic              wb_valid_q, wb_valid_d;
   logic [TAG_W-1:0]  wb_line_q, wb_line_d;
   logic [LINE_W-1:0] wb_data_q, wb_data_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

   logic [TAG_W-1:0]  i_line, d_line;
   logic              i_hit, d_hit, starved;

   assign i_line  = bus.i_addr[ADDR_W-1:OFS];
   assign d_line  = bus.d_addr[ADDR_W-1:OFS];
   assign i_hit   = wb_valid_q && (i_line == wb_line_q);
   assign d_hit   = wb_valid_q && (d_line == wb_line_q);
   assign starved = (starve_q == SW'(STARVE_MAX));

   // NOTE: the buffer and rdata registers are reset as well, so every output reads 0 during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         side_q     <= SIDE_I;
         addr_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_line_q  <= '0;
         wb_data_q  <= '0;
         starve_q   <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         side_q     <= side_d;
         addr_q     <= addr_d;
         wb_valid_q <= wb_valid_d;
         wb_line_q  <= wb_line_d;
         wb_data_q  <= wb_data_d;
         starve_q   <= starve_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // NOTE: every next-state value gets its hold default first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      side_d     = side_q;
      addr_d     = addr_q;
      wb_valid_d = wb_valid_q;
      wb_line_d  = wb_line_q;
      wb_data_d  = wb_data_q;
      starve_d   = starve_q;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.d_write && !wb_valid_q) begin
               wb_valid_d = 1'b1;
               wb_line_d  = d_line;
               wb_data_d  = bus.d_wdata;
               side_d     = SIDE_D;
               state_d    = RESP;
            end else if (bus.d_write) begin
               state_d = DRAIN;
            end else if (bus.d_read && d_hit) begin
               side_d  = SIDE_D;
               state_d = FWD;
            end else if (bus.i_read && i_hit) begin
               side_d   = SIDE_I;
               starve_d = '0;
               state_d  = FWD;
            end else if (bus.i_read && starved) begin
               side_d   = SIDE_I;
               addr_d   = i_line;
               starve_d = '0;
               state_d  = RD_I;
            end else if (bus.d_read) begin
               side_d  = SIDE_D;
               addr_d  = d_line;
               state_d = RD_D;
               // Below the bound here whenever i_read is set, so no saturation check needed.
               if (bus.i_read) starve_d = starve_q + 1'b1;
            end else if (bus.i_read) begin
               side_d   = SIDE_I;
               addr_d   = i_line;
               starve_d = '0;
               state_d  = RD_I;
            end else if (wb_valid_q) begin
               state_d = DRAIN;
            end
         end
         RD_I, RD_D: begin
            if (bus.pmem_resp) begin
               if (state_q == RD_I) i_rdata_d = bus.pmem_rdata;
               else                 d_rdata_d = bus.pmem_rdata;
               state_d = RESP;
            end
         end
         DRAIN: begin
            if (bus.pmem_resp) begin
               wb_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         FWD: begin
            if (side_q == SIDE_I) i_rdata_d = wb_data_q;
            else                  d_rdata_d = wb_data_q;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.pmem_read    = (state_q == RD_I) || (state_q == RD_D);
   assign bus.pmem_write   = (state_q == DRAIN);
   assign bus.pmem_address = ((state_q == RD_I) || (state_q == RD_D)) ? {addr_q, {OFS{1'b0}}} :
                             (state_q == DRAIN) ? {wb_line_q, {OFS{1'b0}}} : '0;
   assign bus.pmem_wdata   = (state_q == DRAIN) ? wb_data_q : '0;
   assign bus.i_resp       = (state_q == RESP) && (side_q == SIDE_I);
   assign bus.d_resp       = (state_q == RESP) && (side_q == SIDE_D);
   assign bus.i_rdata      = i_rdata_q;
   assign bus.d_rdata      = d_rdata_q;
endmodule

// File: tb/tb_pmem_scheduler.sv
// Directed bench for pmem_scheduler: the initial block plays both L1 caches and the memory.
module tb_pmem_scheduler;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   localparam logic [LINE_W-1:0] L_AA = {32{8'hAA}};
   localparam logic [LINE_W-1:0] L_55 = {32{8'h55}};
   localparam logic [LINE_W-1:0] L_66 = {32{8'h66}};
   localparam logic [LINE_W-1:0] L_33 = {32{8'h33}};
   localparam logic [LINE_W-1:0] L_77 = {32{8'h77}};
   localparam logic [LINE_W-1:0] L_88 = {32{8'h88}};
   localparam logic [LINE_W-1:0] L_99 = {32{8'h99}};

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   wr_cnt   = 0;
   int   both_cnt = 0;
   int   cnt0;

   pmem_scheduler_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   pmem_scheduler #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.pmem_read && bus.pmem_write) both_cnt++;
      if (bus.pmem_write && bus.pmem_resp) wr_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [LINE_W-1:0] got,
                        input logic [LINE_W-1:0] expected);
      checks++;
      if (got !== expected) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a pmem strobe, checks it, holds one cycle, then answers it.
   task automatic expect_pmem(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata);
      int n = 0;
      while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_rd"}, LINE_W'(bus.pmem_read), LINE_W'(!wr));
      check({tag, "_wr"}, LINE_W'(bus.pmem_write), LINE_W'(wr));
      check({tag, "_addr"}, LINE_W'(bus.pmem_address), LINE_W'(addr));
      if (wr) check({tag, "_wdata"}, bus.pmem_wdata, wdata);
      tick();
      check({tag, "_hold"}, LINE_W'(bus.pmem_address), LINE_W'(addr));
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = rdata;
      tick();
      bus.pmem_resp  = 1'b0;
   endtask

   initial begin
      rst            = 1'b0;
      bus.i_read     = 1'b0;
      bus.i_addr     = '0;
      bus.d_read     = 1'b0;
      bus.d_write    = 1'b0;
      bus.d_addr     = '0;
      bus.d_wdata    = '0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_iresp", LINE_W'(bus.i_resp), '0);
      check("rst_dresp", LINE_W'(bus.d_resp), '0);
      check("rst_prd", LINE_W'(bus.pmem_read), '0);
      check("rst_pwr", LINE_W'(bus.pmem_write), '0);
      check("rst_paddr", LINE_W'(bus.pmem_address), '0);
      check("rst_pwdata", bus.pmem_wdata, '0);
      check("rst_irdata", bus.i_rdata, '0);
      check("rst_drdata", bus.d_rdata, '0);
      rst = 1'b0;
      tick();

      // I-only read through pmem
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_1234;
      expect_pmem("t1", 1'b0, 32'h0000_1220, '0, L_AA);
      check("t1_iresp", LINE_W'(bus.i_resp), LINE_W'(1));
      check("t1_dresp", LINE_W'(bus.d_resp), '0);
      check("t1_irdata", bus.i_rdata, L_AA);
      check("t1_rd_drop", LINE_W'(bus.pmem_read), '0);
      bus.i_read = 1'b0;
      tick();
      check("t1_pulse", LINE_W'(bus.i_resp), '0);
      check("t1_irdata_hold", bus.i_rdata, L_AA);

      // Buffered write, then a read miss goes ahead of the drain
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h100;
      bus.d_wdata = L_55;
      tick();
      check("t2_wresp", LINE_W'(bus.d_resp), LINE_W'(1));
      check("t2_nowrite", LINE_W'(bus.pmem_write), '0);
      bus.d_write = 1'b0;
      bus.d_read  = 1'b1;
      bus.d_addr  = 32'h200;
      expect_pmem("t2_rd", 1'b0, 32'h200, '0, L_33);
      check("t2_dresp", LINE_W'(bus.d_resp), LINE_W'(1));
      check("t2_drdata", bus.d_rdata, L_33);
      bus.d_read = 1'b0;
      expect_pmem("t2_drain", 1'b1, 32'h100, L_55, '0);
      check("t2_wrcnt", LINE_W'(wr_cnt), LINE_W'(1));
      check("t2_drain_noresp", LINE_W'(bus.d_resp), '0);

      // Read hitting the buffer is forwarded
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h100;
      bus.d_wdata = L_55;
      tick();
      check("t3_wresp", LINE_W'(bus.d_resp), LINE_W'(1));
      bus.d_write = 1'b0;
      bus.d_read  = 1'b1;
      bus.d_addr  = 32'h104;
      tick();
      tick();
      check("t3_fwd_wait", LINE_W'(bus.d_resp), '0);
      check("t3_fwd_nopm1", LINE_W'(bus.pmem_read | bus.pmem_write), '0);
      tick();
      check("t3_fwd_resp", LINE_W'(bus.d_resp), LINE_W'(1));
      check("t3_fwd_data", bus.d_rdata, L_55);
      check("t3_fwd_nopm2", LINE_W'(bus.pmem_read | bus.pmem_write), '0);
      bus.d_read = 1'b0;
      expect_pmem("t3_drain", 1'b1, 32'h100, L_55, '0);

      // Back-to-back writes: the second forces a drain of the first
      cnt0        = wr_cnt;
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h100;
      bus.d_wdata = L_55;
      tick();
      check("t4_wresp1", LINE_W'(bus.d_resp), LINE_W'(1));
      bus.d_addr  = 32'h300;
      bus.d_wdata = L_66;
      expect_pmem("t4_drain", 1'b1, 32'h100, L_55, '0);
      check("t4_drain_noresp", LINE_W'(bus.d_resp), '0);
      tick();
      check("t4_wresp2", LINE_W'(bus.d_resp), LINE_W'(1));
      check("t4_one_write", LINE_W'(wr_cnt - cnt0), LINE_W'(1));
      bus.d_write = 1'b0;
      expect_pmem("t4_drain2", 1'b1, 32'h300, L_66, '0);

      // I starved by continuous D reads: granted after 4 D grants, counter then restarts
      bus.i_read = 1'b1;
      bus.i_addr = 32'h4000;
      bus.d_read = 1'b1;
      bus.d_addr = 32'h800;
      for (int k = 0; k < 4; k++) begin
         expect_pmem($sformatf("t5_d%0d", k), 1'b0, 32'h800 + k * 32'h100, '0, LINE_W'(k + 1));
         check($sformatf("t5_d%0d_resp", k), LINE_W'(bus.d_resp), LINE_W'(1));
         check($sformatf("t5_d%0d_noi", k), LINE_W'(bus.i_resp), '0);
         check($sformatf("t5_d%0d_data", k), bus.d_rdata, LINE_W'(k + 1));
         bus.d_addr = 32'h800 + (k + 1) * 32'h100;
      end
      expect_pmem("t5_i", 1'b0, 32'h4000, '0, L_77);
      check("t5_iresp", LINE_W'(bus.i_resp), LINE_W'(1));
      check("t5_irdata", bus.i_rdata, L_77);
      bus.i_addr = 32'h5000;
      expect_pmem("t5_d_after", 1'b0, 32'h0C00, '0, L_88);
      check("t5_d_after_resp", LINE_W'(bus.d_resp), LINE_W'(1));
      bus.d_read = 1'b0;
      expect_pmem("t5_i2", 1'b0, 32'h5000, '0, L_99);
      check("t5_i2_resp", LINE_W'(bus.i_resp), LINE_W'(1));
      bus.i_read = 1'b0;
      tick();

      // Reset in the middle of a D read with a dirty line buffered
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h600;
      bus.d_wdata = L_55;
      tick();
      check("t6_wresp", LINE_W'(bus.d_resp), LINE_W'(1));
      bus.d_write = 1'b0;
      bus.d_read  = 1'b1;
      bus.d_addr  = 32'hA00;
      tick();
      tick();
      check("t6_rd", LINE_W'(bus.pmem_read), LINE_W'(1));
      check("t6_rd_addr", LINE_W'(bus.pmem_address), LINE_W'(32'hA00));
      rst = 1'b1;
      #1;
      check("t6_rst_prd", LINE_W'(bus.pmem_read), '0);
      check("t6_rst_paddr", LINE_W'(bus.pmem_address), '0);
      check("t6_rst_drdata", bus.d_rdata, '0);
      check("t6_rst_irdata", bus.i_rdata, '0);
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.d_read     = 1'b0;
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = L_AA;
      tick();
      bus.pmem_resp  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t6_noresp%0d", k), LINE_W'(bus.i_resp | bus.d_resp), '0);
         check($sformatf("t6_nodrain%0d", k), LINE_W'(bus.pmem_write), '0);
         tick();
      end

      check("excl_strobes", LINE_W'(both_cnt), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
